// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline and external-memory signals of the shared memory port
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [7:0]  dm_wstrb;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        waiting;
  logic        timeout_err;
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_ack, mem_rdata,
    input  if_inst, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
           mem_wstrb, waiting, timeout_err
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_ack, mem_rdata,
    output if_inst, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
           mem_wstrb, waiting, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access, freezing the pipeline meanwhile
module mem_port_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH, RELEASE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        state;
  logic          if_pend;
  logic          dm_pend;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          ack;
  logic          expire;
  logic          done;
  // A transaction ends on an ack or when the watchdog gives up on its TIMEOUT-th cycle
  always_comb begin
    busy   = state == DATA || state == FETCH;
    ack    = busy && bus.mem_ack;
    expire = busy && !bus.mem_ack && cnt == CW'(TIMEOUT - 1);
    done   = ack || expire;
  end
  // Memory port is steered straight from the state so an async reset drops mem_req at once
  always_comb begin
    bus.mem_req   = busy;
    bus.mem_we    = state == DATA && bus.dm_we;
    bus.mem_addr  = state == DATA ? bus.dm_addr : bus.if_addr;
    bus.mem_wdata = bus.dm_wdata;
    bus.mem_wstrb = (state == DATA && bus.dm_we) ? bus.dm_wstrb : '0;
    bus.waiting   = (state == IDLE && (bus.if_req || bus.dm_req)) || busy;
  end
  // Sequencer: data access first, then fetch, then a single release cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      if_pend         <= 1'b0;
      dm_pend         <= 1'b0;
      cnt             <= '0;
      bus.if_inst     <= NOP_INST;
      bus.dm_rdata    <= '0;
      bus.if_valid    <= 1'b0;
      bus.dm_valid    <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.dm_valid <= 1'b0;
      cnt          <= (busy && !done) ? cnt + CW'(1) : '0;
      if (expire) bus.timeout_err <= 1'b1;
      case (state)
        IDLE: if (bus.if_req || bus.dm_req) begin
          if_pend <= bus.if_req;
          dm_pend <= bus.dm_req;
          state   <= bus.dm_req ? DATA : FETCH;
        end
        DATA: if (done) begin
          if (!bus.dm_we) bus.dm_rdata <= ack ? bus.mem_rdata : '0;
          bus.dm_valid <= !if_pend;
          state        <= if_pend ? FETCH : RELEASE;
        end
        FETCH: if (done) begin
          bus.if_inst  <= ack ? bus.mem_rdata[31:0] : NOP_INST;
          bus.if_valid <= 1'b1;
          bus.dm_valid <= dm_pend;
          state        <= RELEASE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration order, latency, store strobes, watchdog and reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int          n_tests = 0;
  int          n_fail = 0;
  int          lat = 0;
  int          age = 0;
  int          cyc;
  logic        force_ack = 1'b0;
  logic [63:0] data_word = '0;
  logic [31:0] inst_word = '0;
  logic [63:0] addr_q[$];
  logic [63:0] wdata_q[$];
  logic [8:0]  ctl_q[$];
  assign bus.mem_ack   = force_ack || (bus.mem_req && age >= lat);
  assign bus.mem_rdata = bus.mem_addr[13] ? data_word : {32'hFFFF_FFFF, inst_word};
  always @(posedge clk) age <= (bus.mem_req && !bus.mem_ack) ? age + 1 : 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic ir, input logic dr, input logic we, output int c);
    addr_q.delete();
    wdata_q.delete();
    ctl_q.delete();
    bus.if_req = ir;
    bus.dm_req = dr;
    bus.dm_we  = we;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      c++;
      if (!bus.waiting) break;
      if (bus.mem_req && bus.mem_ack) begin
        addr_q.push_back(bus.mem_addr);
        wdata_q.push_back(bus.mem_wdata);
        ctl_q.push_back({bus.mem_we, bus.mem_wstrb});
      end
      @(negedge clk);
    end
    chk("release_reached", bus.waiting, 0);
  endtask
  task automatic done_step();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    @(negedge clk);
    #1;
    chk("pulse_if_valid", bus.if_valid, 0);
    chk("pulse_dm_valid", bus.dm_valid, 0);
    chk("idle_waiting", bus.waiting, 0);
  endtask
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_wstrb = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_inst", bus.if_inst, 64'h13);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_waiting", bus.waiting, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_dm_valid", bus.dm_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    lat = 0; inst_word = 32'h0050_0093; bus.if_addr = 64'h1000;
    req(1, 0, 0, cyc);
    chk("fz_cycles", cyc, 3);
    chk("fz_acks", addr_q.size(), 1);
    chk("fz_addr", addr_q[0], 64'h1000);
    chk("fz_if_inst", bus.if_inst, 64'h0050_0093);
    chk("fz_if_valid", bus.if_valid, 1);
    chk("fz_dm_valid", bus.dm_valid, 0);
    done_step();
    chk("fz_inst_hold", bus.if_inst, 64'h0050_0093);
    lat = 3; data_word = 64'hDEAD_BEEF_CAFE_F00D; inst_word = 32'h00A0_0113;
    bus.dm_addr = 64'h2000; bus.if_addr = 64'h1004;
    req(1, 1, 0, cyc);
    chk("lf_cycles", cyc, 10);
    chk("lf_acks", addr_q.size(), 2);
    chk("lf_addr0", addr_q[0], 64'h2000);
    chk("lf_addr1", addr_q[1], 64'h1004);
    chk("lf_ctl0", ctl_q[0], 0);
    chk("lf_dm_rdata", bus.dm_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("lf_if_inst", bus.if_inst, 64'h00A0_0113);
    chk("lf_dm_valid", bus.dm_valid, 1);
    chk("lf_if_valid", bus.if_valid, 1);
    done_step();
    lat = 1; data_word = 64'h5555_5555_5555_5555; inst_word = 32'h0020_8233;
    bus.dm_addr = 64'h3000; bus.if_addr = 64'h1008;
    bus.dm_wdata = 64'h1122_3344; bus.dm_wstrb = 8'h0F;
    req(1, 1, 1, cyc);
    chk("st_cycles", cyc, 6);
    chk("st_acks", addr_q.size(), 2);
    chk("st_addr0", addr_q[0], 64'h3000);
    chk("st_ctl_data", ctl_q[0], 9'h10F);
    chk("st_ctl_fetch", ctl_q[1], 0);
    chk("st_wdata", wdata_q[0], 64'h1122_3344);
    chk("st_dm_rdata_kept", bus.dm_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("st_dm_valid", bus.dm_valid, 1);
    chk("st_if_inst", bus.if_inst, 64'h0020_8233);
    done_step();
    lat = 0; data_word = 64'h0123_4567_89AB_CDEF; bus.dm_addr = 64'h2008;
    req(0, 1, 0, cyc);
    chk("ld_cycles", cyc, 3);
    chk("ld_dm_rdata", bus.dm_rdata, 64'h0123_4567_89AB_CDEF);
    chk("ld_dm_valid", bus.dm_valid, 1);
    chk("ld_if_valid", bus.if_valid, 0);
    done_step();
    chk("tmo_pre_err", bus.timeout_err, 0);
    lat = 100; bus.if_addr = 64'h100C;
    req(1, 0, 0, cyc);
    chk("tmo_cycles", cyc, 10);
    chk("tmo_if_inst", bus.if_inst, 64'h13);
    chk("tmo_if_valid", bus.if_valid, 1);
    chk("tmo_err", bus.timeout_err, 1);
    done_step();
    lat = 0; inst_word = 32'h0013_5793; bus.if_addr = 64'h1010;
    req(1, 0, 0, cyc);
    chk("tmo2_cycles", cyc, 3);
    chk("tmo2_if_inst", bus.if_inst, 64'h0013_5793);
    chk("tmo2_err_sticky", bus.timeout_err, 1);
    done_step();
    lat = 100; data_word = 64'hAAAA_BBBB_CCCC_DDDD; bus.dm_addr = 64'h2010;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rm_mem_req_before", bus.mem_req, 1);
    #1;
    rst = 1'b1;
    bus.dm_req = 1'b0;
    #1;
    chk("rm_mem_req", bus.mem_req, 0);
    chk("rm_waiting", bus.waiting, 0);
    chk("rm_timeout_err", bus.timeout_err, 0);
    chk("rm_if_inst", bus.if_inst, 64'h13);
    chk("rm_dm_rdata", bus.dm_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rm_late_dm_valid", bus.dm_valid, 0);
      chk("rm_late_if_valid", bus.if_valid, 0);
      chk("rm_late_mem_req", bus.mem_req, 0);
      chk("rm_late_dm_rdata", bus.dm_rdata, 0);
    end
    force_ack = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between instruction fetch (IF stage) and data access (MEM stage) of the 64-bit RISC-V pipeline. It drives the pipeline-wide `waiting` freeze that the D/E/M/W pipeline registers honour. The data access is serviced first (older instruction), then the fetch. Results are presented for one release cycle, in which the pipeline advances. A watchdog substitutes safe values if memory never acknowledges.

## Interface
- TIMEOUT, 255: cycles without `mem_ack` before a transaction is abandoned (≥2).
- NOP_INST, 32'h00000013: instruction returned on reset and on fetch timeout.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch requested this pipeline step
- if_addr  in  64  fetch address, stable while `waiting`=1
- if_inst  out  32  captured instruction
- if_valid  out  1  `if_inst` valid (release cycle only)
- dm_req  in  1  load/store requested this step
- dm_we  in  1  1=store, 0=load
- dm_addr  in  64  data address, stable while `waiting`=1
- dm_wdata  in  64  store data
- dm_wstrb  in  8  store byte enables
- dm_rdata  out  64  captured load data
- dm_valid  out  1  data access complete (release cycle only)
- mem_req  out  1  external transaction active
- mem_we  out  1  external write
- mem_addr  out  64  external address
- mem_wdata  out  64  external write data
- mem_wstrb  out  8  external byte enables (0 on reads)
- mem_ack  in  1  transaction completes this cycle
- mem_rdata  in  64  read data, valid with `mem_ack`
- waiting  out  1  freeze all pipeline registers
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, DATA, FETCH, RELEASE.
- IDLE:
  - If `dm_req` or `if_req`, latch `dm_pend`=`dm_req` and `if_pend`=`if_req`.
  - Next state is DATA if `dm_req`, else FETCH.
  - With no request, stay in IDLE.
- DATA:
  - `mem_req`=1; `mem_addr`=`dm_addr`; `mem_we`=`dm_we`.
  - `mem_wdata`=`dm_wdata`; `mem_wstrb`=`dm_we`?`dm_wstrb`:0.
  - On `mem_ack`, loads capture `mem_rdata` into `dm_rdata`. Stores leave `dm_rdata` unchanged.
  - Next state is FETCH if `if_pend`, else RELEASE.
- FETCH:
  - `mem_req`=1; `mem_we`=0; `mem_addr`=`if_addr`.
  - On `mem_ack`, `if_inst`=`mem_rdata[31:0]`. Next state is RELEASE.
- RELEASE:
  - `if_valid`=`if_pend`; `dm_valid`=`dm_pend`; `waiting`=0. Next state is IDLE.
- `waiting` (combinational) = (IDLE && (`if_req`||`dm_req`)) || DATA || FETCH.
- Outside DATA/FETCH: `mem_req`=0, `mem_we`=0, `mem_wstrb`=0. `mem_ack` is ignored.
- Watchdog:
  - Counter clears on entering DATA/FETCH and increments each cycle without ack.
  - When it reaches TIMEOUT, the transaction is abandoned: `timeout_err`←1, state advances as if acked.
  - Abandoned fetch returns NOP_INST; abandoned load returns 0.
  - `timeout_err` clears only on `rst`.
- Captured `if_inst`/`dm_rdata` hold their values until the next capture.

## Timing
- Reset values: state IDLE; `if_inst`=NOP_INST; `dm_rdata`=0; `if_valid`, `dm_valid`, `timeout_err`, counter = 0.
- Reset mid-transaction: `mem_req` drops immediately (async). A late `mem_ack` after reset is ignored.
- A transaction completes on any cycle with `mem_req`&&`mem_ack`, including the first cycle of the state (zero-wait).
- Back-to-back DATA→FETCH: `mem_req` stays 1, and `mem_addr` changes on the boundary. Each ack completes exactly one transaction.
- Latency with ack latency L (L=0 means same-cycle ack):
  - Fetch only: 3+L cycles from request to release.
  - Load/store + fetch: 4+2L cycles.
- `if_valid`/`dm_valid` are exactly one-cycle pulses, coincident with `waiting`=0 in RELEASE.
- Abandoned transaction: state advances on the TIMEOUT-th waiting cycle. `timeout_err` is visible the following cycle.

## Test plan
- Reset: assert `rst` → `if_inst`=32'h00000013, `dm_rdata`=0, `mem_req`=0, `waiting`=0, `timeout_err`=0.
- Fetch only, zero-wait:
  - Stimulus: `if_req`=1, `if_addr`=0x1000, same-cycle `mem_ack` with `mem_rdata`=0x00500093.
  - Response: `waiting`=1 for 2 cycles, then `if_inst`=0x00500093, `if_valid`=1, `waiting`=0.
- Load + fetch, ack after 3 cycles:
  - Stimulus: `dm_addr`=0x2000, rdata 0xDEADBEEFCAFEF00D; then fetch at 0x1004.
  - Response: `mem_addr` sequence 0x2000 then 0x1004; `dm_rdata`=0xDEADBEEFCAFEF00D; release 10 cycles after request.
- Store:
  - Stimulus: `dm_we`=1, `dm_wstrb`=0x0F, `dm_wdata`=0x11223344.
  - Response: `mem_we`=1, `mem_wstrb`=0x0F only in DATA; 0 in FETCH; `dm_rdata` unchanged; `dm_valid` pulses.
- Timeout: TIMEOUT=8, fetch with no ack → after 8 waiting cycles `if_inst`=0x00000013, `if_valid`=1, and `timeout_err`=1 persists until `rst`.
- Reset mid-DATA: `rst` during the 2nd wait cycle → `mem_req`=0 immediately; a subsequent `mem_ack` causes no capture and no valid pulse.
